cpu_state_dumper: RTL and testbench

- Hardware counterpart of the bench's run-and-check flow, used for on-board runs of the pipelined core.
- After `start`, it counts cycles until the core's PC reaches the exit address plus the pipeline drain offset, or until a timeout.
- It then freezes the core and reads out all 32 architectural registers and the whole data memory.
- Words are streamed out over a valid/ready interface, ending with a status word, so an external checker can compare them against the answer images.

---
 rtl/dumper_pkg.sv | 16 +
 rtl/cpu_state_dumper_stream_out_reg.sv | 34 +++
 rtl/cpu_state_dumper.sv | 107 ++++++++++
 tb/tb_cpu_state_dumper.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dumper_pkg.sv
// dumper_pkg: shared state, tag and status-word definitions for cpu_state_dumper.
package dumper_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DUMP_REG, DUMP_MEM, STATUS, DONE} state_t;
  localparam logic [1:0] TAG_REG = 2'd0;
  localparam logic [1:0] TAG_MEM = 2'd1;
  localparam logic [1:0] TAG_STATUS = 2'd2;
  localparam int STATUS_TO_BIT = 31;
  localparam int STATUS_CNT_W = 31;
  function automatic logic [31:0] status_word(input logic timed_out, input logic [STATUS_CNT_W-1:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STATUS_CNT_W-1:0] = cnt;
    w[STATUS_TO_BIT] = timed_out;
    return w;
  endfunction
endpackage

// File: rtl/cpu_state_dumper_stream_out_reg.sv
// stream_out_reg: one-entry valid/ready output register; loads when empty or draining.
module stream_out_reg
  import dumper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] ld_data,
  input  logic [1:0]  ld_tag,
  input  logic        ld_last,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] data,
  output logic [1:0]  tag,
  output logic        last,
  output logic        accept
);
  assign accept = !valid || ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data <= '0;
      tag <= TAG_REG;
      last <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data <= ld_data;
      tag <= ld_tag;
      last <= ld_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: runs the core to its exit PC or a timeout, then streams registers,
// data memory and a status word over valid/ready.
module cpu_state_dumper
  import dumper_pkg::*;
#(
  parameter int          TIMEOUT = 200,
  parameter int          DRAIN_INSTR = 4,
  parameter int          DATA_BYTES = 1024,
  parameter logic [31:0] DATA_START = 32'h10008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] exit_address,
  input  logic [31:0] pc,
  output logic        halt,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  localparam logic [31:0] MEM_END = DATA_START + 32'(DATA_BYTES) - 32'd4;
  state_t state;
  logic [31:0] exit_q;
  logic [STATUS_CNT_W-1:0] cnt;
  logic timed_out, load, accept, dumping;
  logic [31:0] ld_data;
  logic [1:0] ld_tag;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  // In STATUS the status word is loaded once; while it sits in the register nothing reloads.
  always_comb begin
    dumping = state == DUMP_REG || state == DUMP_MEM;
    load = dumping ? accept : state == STATUS && accept && !(out_valid && out_last);
    ld_data = state == DUMP_REG ? reg_data : state == DUMP_MEM ? dmem_rdata : status_word(timed_out, cnt);
    ld_tag = state == DUMP_REG ? TAG_REG : state == DUMP_MEM ? TAG_MEM : TAG_STATUS;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      exit_q <= '0;
      cnt <= '0;
      timed_out <= 1'b0;
      halt <= 1'b0;
      reg_addr <= '0;
      dmem_addr <= DATA_START;
    end else if (start && (state == IDLE || state == DONE)) begin
      state <= RUN;
      exit_q <= exit_address + 32'(4 * DRAIN_INSTR);
      cnt <= '0;
      timed_out <= 1'b0;
      halt <= 1'b0;
      reg_addr <= '0;
      dmem_addr <= DATA_START;
    end else begin
      case (state)
        RUN: begin
          if (pc == exit_q) begin
            state <= DUMP_REG;
            halt <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == STATUS_CNT_W'(TIMEOUT - 1)) begin
              timed_out <= 1'b1;
              state <= DUMP_REG;
              halt <= 1'b1;
            end
          end
        end
        DUMP_REG: if (load) begin
          reg_addr <= reg_addr + 5'd1;
          if (reg_addr == 5'd31) begin
            state <= DUMP_MEM;
            dmem_addr <= DATA_START;
          end
        end
        DUMP_MEM: if (load) begin
          if (dmem_addr == MEM_END) state <= STATUS;
          else dmem_addr <= dmem_addr + 32'd4;
        end
        STATUS: if (out_valid && out_ready && out_last) state <= DONE;
        default: ;
      endcase
    end
  end
  stream_out_reg u_out (
    .clk(clk),
    .rst(rst),
    .load(load),
    .ld_data(ld_data),
    .ld_tag(ld_tag),
    .ld_last(state == STATUS),
    .ready(out_ready),
    .valid(out_valid),
    .data(out_data),
    .tag(out_tag),
    .last(out_last),
    .accept(accept)
  );
endmodule

// File: tb/tb_cpu_state_dumper.sv
// tb_cpu_state_dumper: directed runs with random register/memory images, checked
// against an expected-beat queue built from the arrays and the pc schedule.
module tb_cpu_state_dumper;
  localparam int TIMEOUT = 200;
  localparam int DRAIN = 4;
  localparam int DATA_BYTES = 1024;
  localparam int NWORDS = DATA_BYTES / 4;
  localparam logic [31:0] DATA_START = 32'h10008000;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [31:0] exit_address = 0, pc = 0;
  logic halt, out_valid, out_last, busy, done;
  logic [4:0] reg_addr;
  logic [31:0] reg_data, dmem_addr, dmem_rdata, out_data;
  logic [1:0] out_tag;
  logic [31:0] regs [32];
  logic [31:0] mem [NWORDS];
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign reg_data = regs[reg_addr];
  assign dmem_rdata = mem[8'((dmem_addr - DATA_START) >> 2)];
  cpu_state_dumper #(
    .TIMEOUT(TIMEOUT), .DRAIN_INSTR(DRAIN), .DATA_BYTES(DATA_BYTES), .DATA_START(DATA_START)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .exit_address(exit_address), .pc(pc),
    .halt(halt), .reg_addr(reg_addr), .reg_data(reg_data), .dmem_addr(dmem_addr),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last), .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask
  task automatic chk_idle(input string pfx);
    chk({pfx, "_halt"}, 32'(halt), 0);
    chk({pfx, "_valid"}, 32'(out_valid), 0);
    chk({pfx, "_data"}, out_data, 0);
    chk({pfx, "_tag"}, 32'(out_tag), 0);
    chk({pfx, "_last"}, 32'(out_last), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_reg_addr"}, 32'(reg_addr), 0);
    chk({pfx, "_dmem_addr"}, dmem_addr, DATA_START);
  endtask
  // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready; abort_at>0 resets after that many beats
  task automatic run(input logic [31:0] ex, input logic [31:0] base, input logic [31:0] step,
                     input logic [31:0] glitch, input int mode, input int abort_at);
    logic [34:0] q[$];
    logic [34:0] e;
    int j, cnt_exp, xfers;
    logic to_exp, pv, pr, pl, finished;
    logic [31:0] pd;
    logic [1:0] pt;
    foreach (regs[i]) regs[i] = $urandom;
    foreach (mem[i]) mem[i] = $urandom;
    to_exp = 1;
    cnt_exp = TIMEOUT;
    for (int k = 0; k < TIMEOUT; k++)
      if (base + step * 32'(k) == ex + 32'(4 * DRAIN)) begin
        cnt_exp = k;
        to_exp = 0;
        break;
      end
    for (int i = 0; i < 32; i++) q.push_back({2'd0, 1'b0, regs[i]});
    for (int i = 0; i < NWORDS; i++) q.push_back({2'd1, 1'b0, mem[i]});
    q.push_back({2'd2, 1'b1, to_exp, 31'(cnt_exp)});
    @(negedge clk);
    start = 1;
    exit_address = ex;
    out_ready = 0;
    @(negedge clk);
    chk("run_busy", 32'(busy), 1);
    j = 0;
    while (!halt && j <= TIMEOUT + 5) begin
      pc = base + step * 32'(j);
      start = (glitch != 0 && j == 3);
      if (start) exit_address = glitch;
      j++;
      @(negedge clk);
    end
    start = 0;
    chk("halt_cycle", 32'(j), 32'(to_exp ? TIMEOUT : cnt_exp + 1));
    chk("halt_set", 32'(halt), 1);
    chk("dump_busy", 32'(busy), 1);
    pv = 0; pr = 0; pd = 0; pt = 0; pl = 0;
    xfers = 0;
    finished = 0;
    for (int c = 0; c < 4000 && !finished; c++) begin
      if (abort_at > 0 && xfers == abort_at) begin
        rst = 1;
        @(negedge clk);
        chk_idle("midrst");
        rst = 0;
        return;
      end
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      if (pv && !pr) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", out_data, pd);
        chk("hold_tag", 32'(out_tag), 32'(pt));
        chk("hold_last", 32'(out_last), 32'(pl));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("beat_data", out_data, e[31:0]);
          chk("beat_tag", 32'(out_tag), 32'(e[34:33]));
          chk("beat_last", 32'(out_last), 32'(e[32]));
          if (q.size() == 0) finished = 1;
        end
        xfers++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pt = out_tag; pl = out_last;
      @(negedge clk);
    end
    chk("stream_finished", 32'(finished), 1);
    chk("beat_count", 32'(xfers), 32'(32 + NWORDS + 1));
    chk("done_flag", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_valid", 32'(out_valid), 0);
    chk("done_halt", 32'(halt), 1);
  endtask
  initial begin
    foreach (regs[i]) regs[i] = 0;
    foreach (mem[i]) mem[i] = 0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 0;
    run(32'h00400020, 32'h00400000, 32'd4, 32'd0, 0, 0);
    run(32'h00400020, 32'h00000000, 32'd0, 32'd0, 0, 0);
    run(32'h00400020, 32'h00400000, 32'd4, 32'd0, 1, 0);
    run(32'h00400100, 32'h00400000, 32'd4, 32'h00400020, 0, 0);
    run(32'h00400000 + 32'd4 * 32'd199 - 32'd16, 32'h00400000, 32'd4, 32'd0, 0, 0);
    run(32'h00400020, 32'h00400000, 32'd4, 32'd0, 0, 42);
    run(32'h00400020, 32'h00400000, 32'd4, 32'd0, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
